// File: rtl/serial_word_adder_if.sv
// Request/result bundle for serial_word_adder.
// When SERIAL_ADDER_OVERFLOW_EN is defined, the bundle also carries the o_v overflow flag.
interface serial_word_adder_if #(
  parameter int BYTES = 4
);
  localparam int W = 8 * BYTES;

  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_c;
  logic         i_sub;
  logic [W-1:0] o_r;
  logic         o_c;
  logic         o_done;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         o_v;

  modport master (
    output i_valid, i_a, i_b, i_c, i_sub,
    input  o_ready, o_r, o_c, o_done, o_v
  );

  modport slave (
    input  i_valid, i_a, i_b, i_c, i_sub,
    output o_ready, o_r, o_c, o_done, o_v
  );
`else
  modport master (
    output i_valid, i_a, i_b, i_c, i_sub,
    input  o_ready, o_r, o_c, o_done
  );

  modport slave (
    input  i_valid, i_a, i_b, i_c, i_sub,
    output o_ready, o_r, o_c, o_done
  );
`endif
endinterface

// File: rtl/serial_word_adder.sv
// Byte-serial add/subtract: one 8-bit slice per clock with a registered carry.
// Defining SERIAL_ADDER_OVERFLOW_EN adds the signed-overflow output o_v.
module serial_word_adder #(
  parameter int BYTES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  serial_word_adder_if.slave bus
);
  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, next_state;
  logic [W-1:0]    a_q, b_q, r_q;
  logic            sub_q, carry_q, c_q;
  logic [IW-1:0]   idx_q;
  logic            ready, done;
  logic            last_byte;
  logic [7:0]      a_byte, b_byte;
  logic [8:0]      sum;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic            v_q;
  logic            msb_carry_in;
`endif

  // Subtraction is A + ~B + ~borrow, so B and the carry are inverted once at accept.
  assign last_byte = (idx_q == IW'(BYTES - 1));
  assign a_byte    = 8'(a_q >> {idx_q, 3'b000});
  assign b_byte    = 8'(b_q >> {idx_q, 3'b000});
  assign sum       = {1'b0, a_byte} + {1'b0, b_byte} + 9'(carry_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.i_valid) next_state = RUN;
      end
      RUN: begin
        if (last_byte) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      idx_q   <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      v_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            a_q     <= bus.i_a;
            b_q     <= bus.i_sub ? ~bus.i_b : bus.i_b;
            sub_q   <= bus.i_sub;
            carry_q <= bus.i_sub ^ bus.i_c;
            idx_q   <= '0;
            r_q     <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < BYTES; k++) begin
            if (idx_q == IW'(k)) r_q[8*k +: 8] <= sum[7:0];
          end
          carry_q <= sum[8];
          // Index parks on the top byte instead of wrapping.
          if (!last_byte) begin
            idx_q <= idx_q + IW'(1);
          end else begin
            c_q <= sub_q ? ~sum[8] : sum[8];
`ifdef SERIAL_ADDER_OVERFLOW_EN
            v_q <= msb_carry_in ^ sum[8];
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign msb_carry_in = a_byte[7] ^ b_byte[7] ^ sum[7];
  assign bus.o_v      = v_q;
`endif

  assign bus.o_ready = ready;
  assign bus.o_done  = done;
  assign bus.o_r     = r_q;
  assign bus.o_c     = c_q;
endmodule

// File: tb/tb_serial_word_adder.sv
// Directed-vector bench for serial_word_adder with BYTES = 4.
// Define SERIAL_ADDER_OVERFLOW_EN to also check o_v.
module tb_serial_word_adder;
  localparam int BYTES = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  serial_word_adder_if #(.BYTES(BYTES)) bus();

  serial_word_adder #(.BYTES(BYTES)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (bus.o_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, ".ready"}, 64'(bus.o_ready), 64'd1);
  endtask

  // One request; operands are scrambled right after accept to show they were latched.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic sub, input logic [31:0] expR,
                               input logic expC, input logic expV);
    int n;
    waitReady(tag);
    bus.i_a = a; bus.i_b = b; bus.i_c = c; bus.i_sub = sub; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_a = ~a; bus.i_b = ~b; bus.i_c = ~c; bus.i_sub = ~sub;
    n = 0;
    while (bus.o_done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, ".latency"}, 64'(n), 64'd4);
    checkOutput({tag, ".r"}, 64'(bus.o_r), 64'(expR));
    checkOutput({tag, ".c"}, 64'(bus.o_c), 64'(expC));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checkOutput({tag, ".v"}, 64'(bus.o_v), 64'(expV));
`else
    if (expV === 1'bx) $display("[TB] unexpected unknown overflow expectation for %s", tag);
`endif
    @(posedge clk); #1;
    checkOutput({tag, ".donePulse"}, 64'(bus.o_done), 64'd0);
    checkOutput({tag, ".readyAfter"}, 64'(bus.o_ready), 64'd1);
    checkOutput({tag, ".rHeld"}, 64'(bus.o_r), 64'(expR));
  endtask

  // Entered on the cycle an accept is expected with i_valid held high.
  task automatic runHold(input string tag, input logic [31:0] nextA, input logic [31:0] nextB,
                         input logic [31:0] expR, input logic expC);
    int         low;
    logic       seen;
    logic [31:0] r;
    logic       cOut;
    @(posedge clk); #1;
    bus.i_a = nextA; bus.i_b = nextB;
    low = 0; seen = 1'b0; r = '0; cOut = 1'b0;
    while (bus.o_ready === 1'b0 && low < 20) begin
      if (bus.o_done === 1'b1) begin
        seen = 1'b1; r = bus.o_r; cOut = bus.o_c;
      end
      @(posedge clk); #1;
      low++;
    end
    checkOutput({tag, ".busyCycles"}, 64'(low), 64'd5);
    checkOutput({tag, ".doneSeen"}, 64'(seen), 64'd1);
    checkOutput({tag, ".r"}, 64'(r), 64'(expR));
    checkOutput({tag, ".c"}, 64'(cOut), 64'(expC));
  endtask

  initial begin
    int doneCount;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_c = 1'b0; bus.i_sub = 1'b0;
    #12;
    checkOutput("reset.ready", 64'(bus.o_ready), 64'd1);
    checkOutput("reset.r", 64'(bus.o_r), 64'd0);
    checkOutput("reset.c", 64'(bus.o_c), 64'd0);
    checkOutput("reset.done", 64'(bus.o_done), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checkOutput("reset.v", 64'(bus.o_v), 64'd0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("addSimple", 32'h000000AA, 32'h00000055, 1'b0, 1'b0, 32'h000000FF, 1'b0, 1'b0);
    applyStimulus("addWrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    applyStimulus("subNeg",    32'h00000012, 32'h00000023, 1'b0, 1'b1, 32'hFFFFFFEF, 1'b1, 1'b0);
    applyStimulus("subBorrow", 32'h00000023, 32'h00000012, 1'b1, 1'b1, 32'h00000010, 1'b0, 1'b0);
    applyStimulus("addOvf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    applyStimulus("subOvf",    32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
    applyStimulus("addAllOnes",32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);

    // Abort after two RUN edges; upper bytes must already be cleared.
    waitReady("abort");
    bus.i_a = 32'h01020304; bus.i_b = 32'h10101010; bus.i_c = 1'b0; bus.i_sub = 1'b0;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort.partialR", 64'(bus.o_r), 64'h00001314);
    checkOutput("abort.busy", 64'(bus.o_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort.ready", 64'(bus.o_ready), 64'd1);
    checkOutput("abort.r", 64'(bus.o_r), 64'd0);
    checkOutput("abort.c", 64'(bus.o_c), 64'd0);
    checkOutput("abort.done", 64'(bus.o_done), 64'd0);
    @(negedge clk); rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.o_done === 1'b1) doneCount++;
    end
    checkOutput("abort.noDone", 64'(doneCount), 64'd0);
    applyStimulus("afterAbort", 32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h21436587, 1'b0, 1'b0);

    // i_valid held high: one accept per IDLE visit, operands taken at each accept.
    waitReady("hold");
    bus.i_a = 32'h11111111; bus.i_b = 32'h22222222; bus.i_c = 1'b0; bus.i_sub = 1'b0;
    bus.i_valid = 1'b1;
    runHold("hold1", 32'h80000000, 32'h80000000, 32'h33333333, 1'b0);
    runHold("hold2", 32'h55555555, 32'h55555555, 32'h00000000, 1'b1);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold.noThird", 64'(bus.o_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
